// File: rtl/serial_parity_framer_pkg.sv
// Shared types and sizing helpers for the serial parity framer and its
// downstream parity checker stages.
package serial_parity_framer_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Wide enough to hold FRAME_LEN itself.
    function automatic int count_width(input int frame_len);
        return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/serial_parity_framer_if.sv
// Serial-in / frame-out handshake bundle. The framer is the slave side;
// whatever feeds bits and consumes frames is the master side.
interface serial_parity_framer_if #(
    parameter int FRAME_LEN = 8
);

    logic                 up_valid;
    logic                 up_bit;
    logic                 up_ready;
    logic                 down_valid;
    logic [FRAME_LEN-1:0] down_data;
    logic                 down_parity;
    logic                 down_ready;

    modport master (
        output up_valid,
        output up_bit,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  down_data,
        input  down_parity
    );

    modport slave (
        input  up_valid,
        input  up_bit,
        input  down_ready,
        output up_ready,
        output down_valid,
        output down_data,
        output down_parity
    );

endinterface

// File: rtl/serial_parity_framer_accum.sv
// Running XOR accumulator. Clear wins over enable, so the caller folds the
// final bit in combinationally when closing a frame.
module serial_parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic r_acc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= 1'b0;
        end else if (en) begin
            r_acc <= r_acc ^ bit_in;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/serial_parity_framer.sv
// Assembles LSB-first serial bits into FRAME_LEN-bit frames with parity and
// holds one completed frame until the consumer takes it.
module serial_parity_framer
    import serial_parity_framer_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_parity_framer_if.slave bus
);

    localparam int               CNT_W      = count_width(FRAME_LEN);
    localparam logic [0:0]       ST_COLLECT = COLLECT;
    localparam logic [0:0]       ST_FULL    = FULL;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);

    generate
        if (FRAME_LEN < 1) begin : g_bad_frame_len
            $error("serial_parity_framer: FRAME_LEN must be at least 1");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [FRAME_LEN-1:0] r_shift;
    logic [FRAME_LEN-1:0] r_down_data;
    logic                 r_down_parity;

    logic                 w_acc;
    logic                 w_up_ready;
    logic                 w_in_beat;
    logic                 w_out_beat;
    logic                 w_last_beat;
    logic [FRAME_LEN-1:0] w_frame;

    // Releasing the held frame frees the buffer in the same cycle, so a bit may be taken then too.
    assign w_up_ready  = !rst && ((r_state == ST_COLLECT) || bus.down_ready);
    assign w_in_beat   = bus.up_valid && w_up_ready;
    assign w_out_beat  = (r_state == ST_FULL) && bus.down_ready;
    assign w_last_beat = w_in_beat && (r_count == LAST_IDX);

    always_comb begin
        w_frame = r_shift;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (r_count == CNT_W'(i)) begin
                w_frame[i] = bus.up_bit;
            end
        end
    end

    serial_parity_accum u_accum (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_last_beat),
        .en     (w_in_beat),
        .bit_in (bus.up_bit),
        .acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_COLLECT;
            r_count       <= '0;
            r_shift       <= '0;
            r_down_data   <= '0;
            r_down_parity <= 1'b0;
        end else begin
            if (w_in_beat) begin
                r_shift <= w_frame;
            end
            if (w_last_beat) begin
                r_state       <= ST_FULL;
                r_count       <= '0;
                r_down_data   <= w_frame;
                r_down_parity <= w_acc ^ bus.up_bit ^ ODD;
            end else begin
                if (w_in_beat) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_out_beat) begin
                    r_state <= ST_COLLECT;
                end
            end
        end
    end

    assign bus.up_ready    = w_up_ready;
    assign bus.down_valid  = (r_state == ST_FULL);
    assign bus.down_data   = r_down_data;
    assign bus.down_parity = r_down_parity;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench for serial_parity_framer: even, odd and single-bit frame
// variants driven from one shared clock and reset.
module tb_serial_parity_framer;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    serial_parity_framer_if #(.FRAME_LEN(8)) b8e ();
    serial_parity_framer_if #(.FRAME_LEN(8)) b8o ();
    serial_parity_framer_if #(.FRAME_LEN(1)) b1 ();

    serial_parity_framer #(.FRAME_LEN(8), .ODD(1'b0)) dut_even (
        .clk (clk),
        .rst (rst),
        .bus (b8e)
    );

    serial_parity_framer #(.FRAME_LEN(8), .ODD(1'b1)) dut_odd (
        .clk (clk),
        .rst (rst),
        .bus (b8o)
    );

    serial_parity_framer #(.FRAME_LEN(1), .ODD(1'b0)) dut_one (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive_even(input logic v, input logic b, input logic dr);
        @(negedge clk);
        b8e.up_valid   = v;
        b8e.up_bit     = b;
        b8e.down_ready = dr;
        #1;
    endtask

    task automatic drive_odd(input logic v, input logic b, input logic dr);
        @(negedge clk);
        b8o.up_valid   = v;
        b8o.up_bit     = b;
        b8o.down_ready = dr;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        b8e.down_ready = 1'b1;
        #1;
        checks++;
        if (b8e.up_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_up_ready: got %b want 0", b8e.up_ready);
        end
        checks++;
        if (b8e.down_valid !== 1'b0 || b8e.down_data !== 8'h00 || b8e.down_parity !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h p=%b want 0/00/0",
                     b8e.down_valid, b8e.down_data, b8e.down_parity);
        end
        checks++;
        if (b1.down_valid !== 1'b0 || b8o.down_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_other_valid: got %b %b want 0 0", b1.down_valid, b8o.down_valid);
        end
        @(negedge clk);
        rst            = 1'b0;
        b8e.down_ready = 1'b0;
        #1;
        checks++;
        if (b8e.up_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL post_reset_up_ready: got %b want 1", b8e.up_ready);
        end
    endtask

    task automatic test_even_frame;
        logic [7:0] bits;
        bits = 8'h0D;
        for (int i = 0; i < 8; i++) begin
            drive_even(1'b1, bits[i], 1'b1);
            if (i == 7) begin
                checks++;
                if (b8e.down_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL even_latency: got valid=%b want 0", b8e.down_valid);
                end
            end
        end
        drive_even(1'b0, 1'b0, 1'b1);
        checks++;
        if (b8e.down_valid !== 1'b1 || b8e.down_data !== 8'h0D || b8e.down_parity !== 1'b1) begin
            fails++;
            $display("[TB] FAIL even_frame: got v=%b d=%h p=%b want 1/0d/1",
                     b8e.down_valid, b8e.down_data, b8e.down_parity);
        end
        drive_even(1'b0, 1'b0, 1'b1);
        checks++;
        if (b8e.down_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL even_release: got valid=%b want 0", b8e.down_valid);
        end
    endtask

    task automatic test_odd_back_to_back;
        logic [7:0] bits;
        bits = 8'h0D;
        for (int i = 0; i < 8; i++) begin
            drive_odd(1'b1, bits[i], 1'b1);
        end
        drive_odd(1'b1, 1'b0, 1'b1);
        checks++;
        if (b8o.down_valid !== 1'b1 || b8o.down_data !== 8'h0D || b8o.down_parity !== 1'b0) begin
            fails++;
            $display("[TB] FAIL odd_frame: got v=%b d=%h p=%b want 1/0d/0",
                     b8o.down_valid, b8o.down_data, b8o.down_parity);
        end
        checks++;
        if (b8o.up_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL odd_b2b_up_ready: got %b want 1", b8o.up_ready);
        end
        for (int i = 1; i < 8; i++) begin
            drive_odd(1'b1, 1'b0, 1'b1);
        end
        drive_odd(1'b0, 1'b0, 1'b1);
        checks++;
        if (b8o.down_valid !== 1'b1 || b8o.down_data !== 8'h00 || b8o.down_parity !== 1'b1) begin
            fails++;
            $display("[TB] FAIL odd_zero_frame: got v=%b d=%h p=%b want 1/00/1",
                     b8o.down_valid, b8o.down_data, b8o.down_parity);
        end
        drive_odd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [7:0] first;
        logic [7:0] second;
        first  = 8'h3C;
        second = 8'hC1;
        for (int i = 0; i < 8; i++) begin
            drive_even(1'b1, first[i], 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            drive_even(1'b1, second[0], 1'b0);
            checks++;
            if (b8e.up_ready !== 1'b0 || b8e.down_valid !== 1'b1 ||
                b8e.down_data !== 8'h3C || b8e.down_parity !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_%0d: got rdy=%b v=%b d=%h p=%b want 0/1/3c/0",
                         k, b8e.up_ready, b8e.down_valid, b8e.down_data, b8e.down_parity);
            end
        end
        drive_even(1'b1, second[0], 1'b1);
        checks++;
        if (b8e.up_ready !== 1'b1 || b8e.down_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL release_cycle: got rdy=%b v=%b want 1/1", b8e.up_ready, b8e.down_valid);
        end
        for (int i = 1; i < 8; i++) begin
            drive_even(1'b1, second[i], 1'b1);
            if (i == 1) begin
                checks++;
                if (b8e.down_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL after_release_valid: got %b want 0", b8e.down_valid);
                end
            end
        end
        drive_even(1'b0, 1'b0, 1'b1);
        checks++;
        if (b8e.down_valid !== 1'b1 || b8e.down_data !== 8'hC1 || b8e.down_parity !== 1'b1) begin
            fails++;
            $display("[TB] FAIL next_frame: got v=%b d=%h p=%b want 1/c1/1",
                     b8e.down_valid, b8e.down_data, b8e.down_parity);
        end
        drive_even(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe;
        drive_even(1'b1, 1'b1, 1'b1);
        drive_even(1'b1, 1'b0, 1'b1);
        drive_even(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        b8e.up_valid = 1'b0;
        rst          = 1'b1;
        #1;
        checks++;
        if (b8e.up_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_up_ready: got %b want 0", b8e.up_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_even(1'b1, 1'b1, 1'b1);
            if (i == 7) begin
                checks++;
                if (b8e.down_valid !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL midreset_early_frame: got valid=%b want 0", b8e.down_valid);
                end
            end
        end
        drive_even(1'b0, 1'b0, 1'b1);
        checks++;
        if (b8e.down_valid !== 1'b1 || b8e.down_data !== 8'hFF || b8e.down_parity !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_frame: got v=%b d=%h p=%b want 1/ff/0",
                     b8e.down_valid, b8e.down_data, b8e.down_parity);
        end
        drive_even(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gapped;
        logic [7:0] bits;
        logic [7:0] seen_data;
        logic       seen_parity;
        int         frames;
        bits        = 8'hA5;
        frames      = 0;
        seen_data   = 8'h00;
        seen_parity = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                drive_even(1'b0, ~bits[i], 1'b1);
                if (b8e.down_valid === 1'b1) frames++;
            end
            drive_even(1'b1, bits[i], 1'b1);
            if (b8e.down_valid === 1'b1) frames++;
        end
        for (int k = 0; k < 4; k++) begin
            drive_even(1'b0, 1'b1, 1'b1);
            if (b8e.down_valid === 1'b1) begin
                frames++;
                seen_data   = b8e.down_data;
                seen_parity = b8e.down_parity;
            end
        end
        checks++;
        if (frames !== 1) begin
            fails++;
            $display("[TB] FAIL gapped_frame_count: got %0d want 1", frames);
        end
        checks++;
        if (seen_data !== 8'hA5 || seen_parity !== 1'b0) begin
            fails++;
            $display("[TB] FAIL gapped_frame: got d=%h p=%b want a5/0", seen_data, seen_parity);
        end
    endtask

    task automatic test_len1;
        logic [2:0] bits;
        bits = 3'b101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b1.down_ready = 1'b1;
            b1.up_valid   = (i < 3);
            b1.up_bit     = (i < 3) ? bits[i] : 1'b0;
            #1;
            if (i > 0) begin
                checks++;
                if (b1.down_valid !== 1'b1 || b1.down_data !== bits[i-1] ||
                    b1.down_parity !== bits[i-1]) begin
                    fails++;
                    $display("[TB] FAIL len1_frame_%0d: got v=%b d=%b p=%b want 1/%b/%b",
                             i - 1, b1.down_valid, b1.down_data, b1.down_parity, bits[i-1], bits[i-1]);
                end
            end
        end
        @(negedge clk);
        b1.up_valid = 1'b0;
        #1;
        checks++;
        if (b1.down_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL len1_drain: got valid=%b want 0", b1.down_valid);
        end
    endtask

    initial begin
        checks         = 0;
        fails          = 0;
        rst            = 1'b1;
        b8e.up_valid   = 1'b0;
        b8e.up_bit     = 1'b0;
        b8e.down_ready = 1'b0;
        b8o.up_valid   = 1'b0;
        b8o.up_bit     = 1'b0;
        b8o.down_ready = 1'b0;
        b1.up_valid    = 1'b0;
        b1.up_bit      = 1'b0;
        b1.down_ready  = 1'b0;

        test_reset();
        test_even_frame();
        test_odd_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_gapped();
        test_len1();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
